// File: rtl/mul_sched_pkg.sv
// Shared definitions for the round-robin multiplier scheduler.
// - id_width(n)       : requester-index width, never narrower than one bit
// - entry_width(w, n) : packed width of one result FIFO entry {data, id}
// - rsp_entry_t       : result FIFO entry at the default WIDTH / N_REQ shape
package mul_sched_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_N_REQ = 4;

  function automatic int id_width(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int entry_width(input int w, input int n);
    return w + id_width(n);
  endfunction

  localparam int DEF_IDW = id_width(DEF_N_REQ);

  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic [DEF_IDW-1:0]   id;
  } rsp_entry_t;

endpackage

// File: rtl/mul_sched_fifo.sv
// Synchronous result FIFO for the multiplier scheduler.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (pointers/count only)
//   push, push_data       write request and entry
//   pop, pop_data         read request and head entry (valid while !empty)
//   count, empty          occupancy and empty flag
// A push and a pop in the same cycle on a full FIFO is accepted and keeps
// the count unchanged.
module mul_sched_fifo #(
  parameter  int WIDTH = 18,
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Credit accounting upstream keeps this from ever firing.
  no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop));

endmodule

// File: rtl/simp_fun.sv
// Registered WIDTH x WIDTH multiplier, two-cycle latency, low WIDTH bits kept.
// Ports:
//   clk          clock
//   rst          synchronous active-high clear
//   a_in, b_in   operands sampled every cycle
//   c_out        product of the operands presented two cycles earlier
module simp_fun #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] c_out
);

  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [WIDTH-1:0] c_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_p0 <= '0;
      b_p0 <= '0;
      c_p1 <= '0;
    end else begin
      // p0: operand capture
      a_p0 <= a_in;
      b_p0 <= b_in;
      // p1: product, truncated by the assignment width
      c_p1 <= a_p0 * b_p0;
    end
  end

  assign c_out = c_p1;

endmodule

// File: rtl/mul_rr_sched.sv
// Round-robin scheduler sharing one registered multiplier among N_REQ requesters.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester operand handshake (at most one ready bit)
//   req_a, req_b         packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready  result handshake, results in issue order
//   rsp_data, rsp_id     product (low WIDTH bits) and originating requester index
//   busy                 something in the multiplier pipe or queued
// Issue is gated by credits so every product in flight is guaranteed a FIFO slot.
module mul_rr_sched
  import mul_sched_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int WIDTH      = 16,
  parameter  int LAT        = 2,
  parameter  int FIFO_DEPTH = 4,
  localparam int IDW        = id_width(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [IDW-1:0]         rsp_id,
  output logic                   busy
);

  localparam int EW    = entry_width(WIDTH, N_REQ);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + LAT + 1);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [IDW-1:0]   id;
  } entry_t;

  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant;
  logic [IDW-1:0]   next_ptr;
  logic             found;
  logic             issue_ok;
  logic             accept;
  logic [OCC_W-1:0] occ;
  logic [LAT-1:0]   vld_pipe;
  logic [IDW-1:0]   id_pipe [LAT];
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_c;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;
  entry_t           push_entry;
  entry_t           head_entry;

  // Issue stage: round-robin search starting at rr_ptr.
  always_comb begin
    logic [IDW-1:0] idx;
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // Registered count only, so a pop frees its credit one cycle later.
  always_comb begin
    occ = OCC_W'(fifo_count);
    for (int i = 0; i < LAT; i++) begin
      occ = occ + OCC_W'(vld_pipe[i]);
    end
  end

  assign issue_ok = rst_n && (occ < OCC_W'(FIFO_DEPTH));
  assign accept   = found && issue_ok;
  assign next_ptr = (grant == IDW'(N_REQ - 1)) ? '0 : grant + IDW'(1);

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  assign mul_a = accept ? req_a[int'(grant)*WIDTH +: WIDTH] : '0;
  assign mul_b = accept ? req_b[int'(grant)*WIDTH +: WIDTH] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      vld_pipe <= '0;
    end else begin
      if (accept) rr_ptr <= next_ptr;
      vld_pipe[0] <= accept;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    id_pipe[0] <= grant;
    for (int i = 1; i < LAT; i++) begin
      id_pipe[i] <= id_pipe[i-1];
    end
  end

  // Multiply stages: validity is tracked by vld_pipe, never by the datapath.
  simp_fun #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk   (clk),
    .rst   (1'b0),
    .a_in  (mul_a),
    .b_in  (mul_b),
    .c_out (mul_c)
  );

  // Result stage: product and its ID enter the FIFO together.
  assign push_entry = '{data: mul_c, id: id_pipe[LAT-1]};

  mul_sched_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vld_pipe[LAT-1]),
    .push_data (push_entry),
    .pop       (rsp_valid && rsp_ready),
    .pop_data  (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = head_entry.data;
  assign rsp_id    = head_entry.id;
  assign busy      = (|vld_pipe) || !fifo_empty;

endmodule

// File: tb/tb_mul_rr_sched.sv
module tb_mul_rr_sched;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] a [4];
  logic [15:0] b [4];
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_data_q [$];
  logic [1:0]  exp_id_q [$];

  assign req_a = {a[3], a[2], a[1], a[0]};
  assign req_b = {b[3], b[2], b[1], b[0]};

  mul_rr_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Settle, score any response transferring at the coming edge, then advance.
  task automatic step();
    #1;
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      checks++;
      assert (exp_id_q.size() != 0) else begin
        errors++;
        $error("FAIL rsp_unexpected: observed id=%0d data=%0h expected no response", rsp_id, rsp_data);
      end
      if (exp_id_q.size() != 0) begin
        chk("rsp_data", 32'(rsp_data), 32'(exp_data_q.pop_front()));
        chk("rsp_id", 32'(rsp_id), 32'(exp_id_q.pop_front()));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Check that exactly requester g is accepted this cycle and log its product.
  task automatic expect_accept(input int g, input logic [15:0] prod);
    logic [3:0] onehot;
    #1;
    onehot = 4'b0001 << g;
    chk("req_ready", 32'(req_ready), 32'(onehot));
    exp_id_q.push_back(2'(g));
    exp_data_q.push_back(prod);
  endtask

  initial begin
    logic [15:0] prod_a [4];
    logic [15:0] prod_bp [4];
    logic [15:0] prod_rs [4];
    int          grant_e [6];

    prod_a  = '{16'd6, 16'd9, 16'd12, 16'd15};
    prod_bp = '{16'd6, 16'd12, 16'd18, 16'd24};
    prod_rs = '{16'd60, 16'd66, 16'd72, 16'd78};
    grant_e = '{2, 0, 2, 0, 1, 2};

    rst_n     = 1'b0;
    req_valid = 4'h0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    req_valid = 4'hF;
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    req_valid = 4'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All four requesters continuously valid: 0,1,2,3,0,1,2,3.
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a[i] = 16'(i + 2);
      b[i] = 16'd3;
    end
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      expect_accept(k % 4, prod_a[k % 4]);
      step();
    end
    req_valid = 4'h0;
    #1;
    chk("idle_req_ready", 32'(req_ready), 32'h0);
    for (int k = 0; k < 5; k++) step();
    chk("rr_drained", 32'(exp_id_q.size()), 32'h0);
    chk("rr_busy_idle", 32'(busy), 32'h0);

    // Single request, three-cycle latency.
    a[0] = 16'd3;
    b[0] = 16'd5;
    req_valid = 4'h1;
    expect_accept(0, 16'd15);
    step();
    req_valid = 4'h0;
    chk("lat_c1_valid", 32'(rsp_valid), 32'h0);
    chk("lat_c1_busy", 32'(busy), 32'h1);
    step();
    chk("lat_c2_valid", 32'(rsp_valid), 32'h0);
    step();
    chk("lat_c3_valid", 32'(rsp_valid), 32'h1);
    chk("lat_c3_data", 32'(rsp_data), 32'd15);
    chk("lat_c3_id", 32'(rsp_id), 32'd0);
    step();
    chk("lat_c4_valid", 32'(rsp_valid), 32'h0);
    chk("lat_c4_busy", 32'(busy), 32'h0);

    // Truncation to the low 16 bits.
    a[1] = 16'hFFFF;
    b[1] = 16'h0002;
    req_valid = 4'h2;
    expect_accept(1, 16'hFFFE);
    step();
    a[1] = 16'h0100;
    b[1] = 16'h0100;
    expect_accept(1, 16'h0000);
    step();
    req_valid = 4'h0;
    for (int k = 0; k < 5; k++) step();
    chk("trunc_drained", 32'(exp_id_q.size()), 32'h0);

    // Backpressure: four credits, then stall until the consumer drains.
    rsp_ready = 1'b0;
    b[1] = 16'd6;
    req_valid = 4'h2;
    for (int k = 0; k < 4; k++) begin
      a[1] = 16'(k + 1);
      expect_accept(1, prod_bp[k]);
      step();
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_stalled", 32'(req_ready), 32'h0);
      step();
    end
    chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("bp_head_data", 32'(rsp_data), 32'd6);
    chk("bp_head_id", 32'(rsp_id), 32'd1);
    step();
    chk("bp_hold_data", 32'(rsp_data), 32'd6);
    chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
    rsp_ready = 1'b1;
    #1;
    chk("bp_credit_delay", 32'(req_ready), 32'h0);
    step();
    for (int k = 0; k < 4; k++) begin
      a[1] = 16'(k + 10);
      expect_accept(1, prod_rs[k]);
      step();
    end
    req_valid = 4'h0;
    for (int k = 0; k < 8; k++) step();
    chk("bp_drained", 32'(exp_id_q.size()), 32'h0);
    chk("bp_busy_idle", 32'(busy), 32'h0);

    // Fairness: 0 and 2 alternate, a late requester 1 gets in within two grants.
    a[0] = 16'd1; b[0] = 16'd1;
    a[1] = 16'd3; b[1] = 16'd3;
    a[2] = 16'd2; b[2] = 16'd2;
    req_valid = 4'h5;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) req_valid = 4'h7;
      expect_accept(grant_e[k], (grant_e[k] == 0) ? 16'd1 : (grant_e[k] == 1) ? 16'd9 : 16'd4);
      step();
    end
    req_valid = 4'h0;
    for (int k = 0; k < 6; k++) step();
    chk("fair_drained", 32'(exp_id_q.size()), 32'h0);

    // Reset with two in flight and one queued.
    rsp_ready = 1'b0;
    a[0] = 16'd4;
    b[0] = 16'd4;
    req_valid = 4'h1;
    for (int k = 0; k < 3; k++) begin
      expect_accept(0, 16'd16);
      step();
    end
    req_valid = 4'h0;
    chk("pre_rst_valid", 32'(rsp_valid), 32'h1);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    req_valid = 4'hF;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    exp_id_q.delete();
    exp_data_q.delete();
    step();
    step();
    rst_n = 1'b1;
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("post_rst_no_stale", 32'(rsp_valid), 32'h0);
    end
    chk("post_rst_busy", 32'(busy), 32'h0);
    a[0] = 16'd3;
    b[0] = 16'd5;
    req_valid = 4'hF;
    expect_accept(0, 16'd15);
    step();
    req_valid = 4'h0;
    for (int k = 0; k < 5; k++) step();
    chk("final_drained", 32'(exp_id_q.size()), 32'h0);
    chk("final_busy", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
